// File: rtl/dla_hld_ram_read_credit_buffer_if.sv
// Request / RAM / response signal bundle for the credit-based stitched-RAM read front end.
// slave is the buffer's view; master is the requester/RAM/consumer side.
interface dla_hld_ram_read_credit_buffer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_read_enable;
  logic [WIDTH-1:0]      ram_readdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  idle;

  modport slave (
    input  req_valid, req_address, ram_readdata, rsp_ready,
    output req_ready, ram_address, ram_read_enable, rsp_valid, rsp_data, idle
  );

  modport master (
    output req_valid, req_address, ram_readdata, rsp_ready,
    input  req_ready, ram_address, ram_read_enable, rsp_valid, rsp_data, idle
  );
endinterface

// File: rtl/dla_hld_ram_read_credit_buffer.sv
// Read front end for a depth-stitched RAM: credits bound in-flight reads plus buffered
// responses to FIFO_DEPTH, so returning data always has a FIFO slot waiting for it.
module dla_hld_ram_read_credit_buffer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clock,
  input  logic                           resetn,
  dla_hld_ram_read_credit_buffer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [CW-1:0]           credits_q, credits_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0]        mem_q [FIFO_DEPTH];

  logic                  req_ready;
  logic                  rsp_valid;
  logic                  fire;
  logic                  pop;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;

  // Ready/valid come only from flops; fire is gated by resetn so no enable leaks while reset is held.
  always_comb begin
    req_ready = (credits_q != '0);
    rsp_valid = (count_q != '0);
    fire      = bus.req_valid & req_ready & resetn;
    pop       = rsp_valid & bus.rsp_ready;
    wr_en     = vld_pipe_q[READ_LATENCY-1];
    addr      = bus.req_address;
  end

  always_comb begin
    credits_d = credits_q;
    if (fire && !pop)
      credits_d = credits_q - 1'b1;
    else if (pop && !fire)
      credits_d = credits_q + 1'b1;
  end

  // Latency tracker never stalls: the credit check already guaranteed a slot.
  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = fire;
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !wr_en)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      credits_q  <= DEPTH_C;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_pipe_q <= '0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Storage is data-only; validity lives in count_q, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= bus.ram_readdata;
  end

  assign bus.req_ready       = req_ready;
  assign bus.rsp_valid       = rsp_valid;
  assign bus.rsp_data        = rsp_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.ram_address     = addr;
  assign bus.ram_read_enable = fire;
  assign bus.idle            = (credits_q == DEPTH_C);

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(wr_en && (count_q == DEPTH_C)));

  a_credit_balance: assert property (@(posedge clock) disable iff (!resetn)
    (int'(credits_q) + int'(count_q) + $countones(vld_pipe_q)) == FIFO_DEPTH);
endmodule
